// File: rtl/fp_add_issue_queue.sv
// fp_add_issue_queue: credit-based valid/ready wrapper around a fixed-latency,
// non-stallable FP adder. Requests are issued to the adder only while a
// result slot is guaranteed. Results and tags are captured in an in-order
// show-ahead FIFO and handed to the consumer.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_DRAIN | after reset: no issue, done tokens dropped, LATENCY cycles
//   ST_RUN   | normal issue/capture; left only through reset
module fp_add_issue_queue #(
  parameter int LATENCY = 14,
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [TAG_W:0]   fpu_go,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic [TAG_W:0]   fpu_done,
  input  logic [31:0]      fpu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = $clog2(LATENCY + 1);
  localparam int EW  = TAG_W + 32;

  typedef enum logic {ST_DRAIN, ST_RUN} state_t;

  state_t         state_q;
  logic [DCW-1:0] drain_cnt_q;
  logic [CW-1:0]  credits_q, credits_d;
  logic [CW-1:0]  count_q, count_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic           overflow_q;
  logic [EW-1:0]  mem_q [DEPTH];

  logic run;
  logic accept;
  logic pop;
  logic push;
  logic full;
  logic write_en;

  // Issue side: accept only in RUN with a free credit; token goes out same cycle.
  always_comb begin
    run       = (state_q == ST_RUN) && !reset;
    req_ready = run && (credits_q != '0);
    accept    = req_valid && req_ready;
    fpu_go    = accept ? {req_tag, 1'b1} : '0;
    fpu_a     = req_a;
    fpu_b     = req_b;
  end

  // FIFO control: show-ahead head, push on done token, full-with-pop is legal.
  always_comb begin
    resp_valid  = (count_q != '0);
    resp_result = mem_q[rd_ptr_q][31:0];
    resp_tag    = mem_q[rd_ptr_q][EW-1:32];
    pop         = resp_valid && resp_ready;
    full        = (count_q == CW'(DEPTH));
    push        = run && fpu_done[0];
    write_en    = push && (!full || pop);
    count_d     = count_q;
    if (write_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!write_en && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Credit return happens on pop, not on capture, so an in-flight op always owns a slot.
  always_comb begin
    credits_d = credits_q;
    if (accept && !pop) begin
      credits_d = credits_q - 1'b1;
    end else if (pop && !accept) begin
      credits_d = credits_q + 1'b1;
    end
  end

  // Drain FSM: flushes tokens still inside the un-resettable adder.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_DRAIN;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_DRAIN: begin
          if (drain_cnt_q == DCW'(LATENCY - 1)) begin
            state_q <= ST_RUN;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Credits, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      credits_q  <= CW'(DEPTH);
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      count_q   <= count_d;
      if (write_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Result storage; with full+pop the write lands in the slot being vacated.
  always_ff @(posedge clock) begin
    if (write_en) begin
      mem_q[wr_ptr_q] <= {fpu_done[TAG_W:1], fpu_result};
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_fp_add_issue_queue.sv
// Bench for fp_add_issue_queue: behavioural 14-stage adder model driven by
// fpu_go, scoreboard queue filled on accept, monitor popping on resp handshakes.
module tb_fp_add_issue_queue;
  localparam int LAT   = 14;
  localparam int DEPTH = 16;
  localparam int TAG_W = 7;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic [TAG_W:0]   fpu_go;
  logic [31:0]      fpu_a, fpu_b;
  logic [TAG_W:0]   fpu_done;
  logic [31:0]      fpu_result;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_result;
  logic [TAG_W-1:0] resp_tag;
  logic             overflow;

  fp_add_issue_queue #(.LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_go(fpu_go), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result), .resp_tag(resp_tag),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Hand-computed single-precision sums: 1+2, 2+2, 1-1, 3+1, .5+.5, 10+5, 5-3, 1.5+1.5
  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic [31:0] vs [8];
  initial begin
    va = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000,
           32'h3F000000, 32'h41200000, 32'h40A00000, 32'h3FC00000};
    vb = '{32'h40000000, 32'h40000000, 32'hBF800000, 32'h3F800000,
           32'h3F000000, 32'h40A00000, 32'hC0400000, 32'h3FC00000};
    vs = '{32'h40400000, 32'h40800000, 32'h00000000, 32'h40800000,
           32'h3F800000, 32'h41700000, 32'h40000000, 32'h40400000};
  end

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++) begin
      if (va[i] == a && vb[i] == b) return vs[i];
    end
    return a + b;
  endfunction

  // Adder model: fixed latency, no reset, no backpressure.
  logic [TAG_W:0] p_go [LAT];
  logic [31:0]    p_a  [LAT];
  logic [31:0]    p_b  [LAT];
  always @(posedge clock) begin
    p_go[0] <= fpu_go;
    p_a[0]  <= fpu_a;
    p_b[0]  <= fpu_b;
    for (int i = 1; i < LAT; i++) begin
      p_go[i] <= p_go[i-1];
      p_a[i]  <= p_a[i-1];
      p_b[i]  <= p_b[i-1];
    end
  end

  logic           force_v;
  logic [TAG_W:0] force_tok;
  logic [31:0]    force_res;
  assign fpu_done   = force_v ? force_tok : p_go[LAT-1];
  assign fpu_result = force_v ? force_res : fadd(p_a[LAT-1], p_b[LAT-1]);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  int pops = 0;
  int last_pop_cyc = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (!reset && resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got tag %0h result %0h expected none (cycle %0d)",
                   resp_tag, resp_result, cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_tag", 64'(resp_tag), 64'(e.tag));
          chk("resp_result", 64'(resp_result), 64'(e.res));
        end
        pops++;
        last_pop_cyc = cyc;
      end
    end
  end

  // Call right after a negedge: presents a request, records it if accepted.
  task automatic offer(input int v, input logic [TAG_W-1:0] tag, output bit acc);
    req_valid = 1'b1;
    req_a     = va[v];
    req_b     = vb[v];
    req_tag   = tag;
    #1;
    acc = req_ready;
    if (acc) sb.push_back({tag, vs[v]});
  endtask

  // Call at the negedge where reset has just dropped.
  task automatic wait_drain();
    for (int i = 0; i < LAT; i++) begin
      #1;
      chk("drain_ready", 64'(req_ready), 64'd0);
      chk("drain_resp_valid", 64'(resp_valid), 64'd0);
      @(negedge clock);
    end
    #1;
    chk("run_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic wait_resp(input string name);
    int lat;
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    #1;
    while (!resp_valid && lat < 40) begin
      @(negedge clock);
      lat++;
      #1;
    end
    chk(name, 64'(lat), 64'd15);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 120) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    #3;
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int t0, drops, p0, accepted;

    reset = 1'b1; req_valid = 1'b1; req_a = '0; req_b = '0; req_tag = 7'h11;
    resp_ready = 1'b0; force_v = 1'b0; force_tok = '0; force_res = '0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_fpu_go", 64'(fpu_go), 64'd0);
    @(negedge clock);
    reset = 1'b0; req_valid = 1'b0;
    wait_drain();

    // Single op
    @(negedge clock);
    resp_ready = 1'b1;
    offer(0, 7'd5, acc);
    chk("single_accept", 64'(acc), 64'd1);
    chk("single_go", 64'(fpu_go), 64'h0B);
    chk("single_fpu_a", 64'(fpu_a), 64'h3F800000);
    chk("single_fpu_b", 64'(fpu_b), 64'h40000000);
    wait_resp("single_latency");
    wait_empty("single_drained");

    // Streaming
    drops = 0; t0 = 0; p0 = pops;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      offer(i % 8, 7'(i), acc);
      if (i == 0) t0 = cyc;
      if (!acc) drops++;
    end
    @(negedge clock);
    req_valid = 1'b0;
    wait_empty("stream_drained");
    chk("stream_drops", 64'(drops), 64'd0);
    chk("stream_pops", 64'(pops - p0), 64'd40);
    chk("stream_last_pop", 64'(last_pop_cyc), 64'(t0 + 15 + 39));

    // Backpressure: only DEPTH accepted
    @(negedge clock);
    resp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      offer(i % 8, 7'(64 + i), acc);
      if (acc) accepted++;
    end
    chk("bp_accepted", 64'(accepted), 64'd16);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    chk("bp_resp_valid", 64'(resp_valid), 64'd1);
    chk("bp_overflow", 64'(overflow), 64'd0);
    chk("bp_head_tag", 64'(resp_tag), 64'd64);

    // Stray done token into the full FIFO
    @(negedge clock);
    force_v = 1'b1; force_tok = {7'h55, 1'b1}; force_res = 32'hDEADBEEF;
    @(negedge clock);
    force_v = 1'b0;
    #1;
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_head_tag", 64'(resp_tag), 64'd64);
    chk("ovf_head_result", 64'(resp_result), 64'h40400000);

    // One pop frees one credit for the following cycle
    @(negedge clock);
    resp_ready = 1'b1;
    #1;
    chk("pop_ready_before", 64'(req_ready), 64'd0);
    @(negedge clock);
    resp_ready = 1'b0;
    #1;
    chk("pop_ready_after", 64'(req_ready), 64'd1);

    // Accept and pop together at credits = 1
    @(negedge clock);
    resp_ready = 1'b1;
    offer(2, 7'h70, acc);
    chk("ap_accept", 64'(acc), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    chk("ap_ready", 64'(req_ready), 64'd1);
    wait_empty("ap_drained");
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Reset mid-flight
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      offer(i % 8, 7'(i), acc);
    end
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_go", 64'(fpu_go), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    wait_drain();
    @(negedge clock);
    offer(5, 7'h2A, acc);
    chk("post_rst_accept", 64'(acc), 64'd1);
    wait_resp("post_rst_latency");
    repeat (20) @(negedge clock);
    #3;
    chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);
    chk("post_rst_idle", 64'(resp_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
